// File: rtl/sweep_acq_multi_ctrl_if.sv
// Signal bundle between the sweep controller and its SC/acquisition/USB environment.
// The master modport is the controller side; slave is the environment side.
interface sweep_acq_multi_ctrl_if #(
    parameter int DAC_WIDTH = 10,
    parameter int NUM_DAC   = 3,
    parameter int CNT_WIDTH = 16,
    parameter int TO_WIDTH  = 24
);
    logic                         SweepStart;
    logic                         SweepStop;
    logic [1:0]                   DacSelect;
    logic [DAC_WIDTH-1:0]         StartDAC;
    logic [DAC_WIDTH-1:0]         EndDAC;
    logic [DAC_WIDTH-1:0]         DacStep;
    logic [CNT_WIDTH-1:0]         MaxPackageNumber;
    logic [TO_WIDTH-1:0]          AcqTimeout;
    logic [NUM_DAC*DAC_WIDTH-1:0] OutDAC;
    logic                         LoadSCParameter;
    logic                         MicrorocConfigDone;
    logic                         SingleACQStart;
    logic                         ForceMicrorocAcqReset;
    logic                         ParallelData_en;
    logic [15:0]                  SweepACQData;
    logic                         SweepACQData_en;
    logic                         UsbDataFifoFull;
    logic                         ACQDone;
    logic                         DataTransmitDone;
    logic                         SweepBusy;

    modport master (
        input  SweepStart, SweepStop, DacSelect, StartDAC, EndDAC, DacStep,
               MaxPackageNumber, AcqTimeout, MicrorocConfigDone, ParallelData_en,
               UsbDataFifoFull, DataTransmitDone,
        output OutDAC, LoadSCParameter, SingleACQStart, ForceMicrorocAcqReset,
               SweepACQData, SweepACQData_en, ACQDone, SweepBusy
    );

    modport slave (
        output SweepStart, SweepStop, DacSelect, StartDAC, EndDAC, DacStep,
               MaxPackageNumber, AcqTimeout, MicrorocConfigDone, ParallelData_en,
               UsbDataFifoFull, DataTransmitDone,
        input  OutDAC, LoadSCParameter, SingleACQStart, ForceMicrorocAcqReset,
               SweepACQData, SweepACQData_en, ACQDone, SweepBusy
    );
endinterface

// File: rtl/sweep_acq_multi_ctrl.sv
// DAC-sweep S-curve acquisition controller: steps one DAC, reconfigures SC, acquires per point,
// and streams a 3-word record per point plus a trailer into the USB FIFO path.
//
//  state    | meaning
//  IDLE     | waiting for SweepStart rising edge
//  LOAD     | 1-cycle LoadSCParameter pulse
//  CFG_WAIT | waiting for MicrorocConfigDone
//  ACQ      | SingleACQStart high, counting packages / timeout
//  STOP     | ForceMicrorocAcqReset pulse
//  WR0..WR2 | record words (header, flag+DAC, count)
//  NEXT     | step DAC or finish
//  WR_TRL   | trailer word
//  DONE     | ACQDone high until DataTransmitDone
module sweep_acq_multi_ctrl #(
    parameter int          DAC_WIDTH = 10,
    parameter int          NUM_DAC   = 3,
    parameter int          CNT_WIDTH = 16,
    parameter int          TO_WIDTH  = 24,
    parameter logic [15:0] HEADER    = 16'hC0C0,
    parameter logic [15:0] TRAILER   = 16'hFFFF
) (
    input logic                  Clk,
    input logic                  reset_n,
    sweep_acq_multi_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CFG_WAIT, S_ACQ, S_STOP,
        S_WR0, S_WR1, S_WR2, S_NEXT, S_WR_TRL, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 start_prev_q;
    logic [1:0]           ch_q, ch_d;
    logic [DAC_WIDTH-1:0] start_q, start_d, end_q, end_d, step_q, step_d, dac_q, dac_d;
    logic                 up_q, up_d;
    logic [CNT_WIDTH-1:0] max_q, max_d, cnt_q, cnt_d, cnt_now;
    logic [TO_WIDTH-1:0]  to_q, to_d, tmr_q, tmr_d;
    logic                 tflag_q, tflag_d, stop_q, stop_d;
    logic [DAC_WIDTH:0]   nxt;
    logic                 past_end;
    logic [15:0]          wr_word;
    state_t               wr_next;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            ch_q         <= '0;
            start_q      <= '0;
            end_q        <= '0;
            step_q       <= '0;
            dac_q        <= '0;
            up_q         <= 1'b0;
            max_q        <= '0;
            cnt_q        <= '0;
            to_q         <= '0;
            tmr_q        <= '0;
            tflag_q      <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= bus.SweepStart;
            ch_q         <= ch_d;
            start_q      <= start_d;
            end_q        <= end_d;
            step_q       <= step_d;
            dac_q        <= dac_d;
            up_q         <= up_d;
            max_q        <= max_d;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            tmr_q        <= tmr_d;
            tflag_q      <= tflag_d;
            stop_q       <= stop_d;
        end
    end

    // One extra bit catches wrap past either end of the DAC code range.
    assign nxt = up_q ? ({1'b0, dac_q} + {1'b0, step_q}) : ({1'b0, dac_q} - {1'b0, step_q});
    assign past_end = nxt[DAC_WIDTH] ||
                      (up_q ? (nxt[DAC_WIDTH-1:0] > end_q) : (nxt[DAC_WIDTH-1:0] < end_q));

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        start_d   = start_q;
        end_d     = end_q;
        step_d    = step_q;
        dac_d     = dac_q;
        up_d      = up_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        tmr_d     = tmr_q;
        tflag_d   = tflag_q;
        stop_d    = stop_q;
        cnt_now   = cnt_q;
        wr_word   = 16'h0000;
        wr_next   = state_q;
        bus.LoadSCParameter       = 1'b0;
        bus.SingleACQStart        = 1'b0;
        bus.ForceMicrorocAcqReset = 1'b0;
        bus.SweepACQData          = 16'h0000;
        bus.SweepACQData_en       = 1'b0;
        bus.ACQDone               = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.SweepStart && !start_prev_q) begin
                    ch_d    = bus.DacSelect;
                    start_d = bus.StartDAC;
                    end_d   = bus.EndDAC;
                    step_d  = (bus.DacStep == '0) ? DAC_WIDTH'(1) : bus.DacStep;
                    dac_d   = bus.StartDAC;
                    up_d    = (bus.StartDAC <= bus.EndDAC);
                    max_d   = bus.MaxPackageNumber;
                    to_d    = bus.AcqTimeout;
                    stop_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.LoadSCParameter = 1'b1;
                cnt_d   = '0;
                tflag_d = 1'b0;
                if (bus.SweepStop) begin
                    stop_d  = 1'b1;
                    state_d = S_WR_TRL;
                end else begin
                    state_d = S_CFG_WAIT;
                end
            end
            S_CFG_WAIT: begin
                tmr_d = to_q;
                if (bus.SweepStop) begin
                    stop_d  = 1'b1;
                    state_d = S_WR_TRL;
                end else if (bus.MicrorocConfigDone) begin
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                bus.SingleACQStart = 1'b1;
                if (bus.ParallelData_en && (cnt_q != max_q))
                    cnt_now = cnt_q + CNT_WIDTH'(1);
                cnt_d = cnt_now;
                if (tmr_q != '0)
                    tmr_d = tmr_q - TO_WIDTH'(1);
                // Stop has priority; the flag only records a genuine timeout exit.
                if (bus.SweepStop) begin
                    stop_d  = 1'b1;
                    state_d = S_STOP;
                end else if (cnt_now == max_q) begin
                    state_d = S_STOP;
                end else if ((to_q != '0) && (tmr_q == TO_WIDTH'(1))) begin
                    tflag_d = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                bus.ForceMicrorocAcqReset = 1'b1;
                if (bus.SweepStop) stop_d = 1'b1;
                state_d = S_WR0;
            end
            S_WR0, S_WR1, S_WR2, S_WR_TRL: begin
                case (state_q)
                    S_WR0:   begin wr_word = {HEADER[15:2], ch_q};      wr_next = S_WR1;  end
                    S_WR1:   begin wr_word = {tflag_q, 15'(dac_q)};     wr_next = S_WR2;  end
                    S_WR2:   begin wr_word = 16'(cnt_q);                wr_next = S_NEXT; end
                    default: begin wr_word = TRAILER;                   wr_next = S_DONE; end
                endcase
                bus.SweepACQData    = wr_word;
                bus.SweepACQData_en = !bus.UsbDataFifoFull;
                if (bus.SweepStop) stop_d = 1'b1;
                if (!bus.UsbDataFifoFull) state_d = wr_next;
            end
            S_NEXT: begin
                if (stop_q || bus.SweepStop || past_end) begin
                    state_d = S_WR_TRL;
                end else begin
                    dac_d   = nxt[DAC_WIDTH-1:0];
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                bus.ACQDone = 1'b1;
                if (bus.DataTransmitDone) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.OutDAC = '0;
        for (int g = 0; g < NUM_DAC; g++)
            bus.OutDAC[g*DAC_WIDTH +: DAC_WIDTH] = (ch_q == 2'(g)) ? dac_q : start_q;
    end

    assign bus.SweepBusy = (state_q != S_IDLE);
endmodule

// File: tb/tb_sweep_acq_multi_ctrl.sv
// Self-checking bench for sweep_acq_multi_ctrl: randomized packet/backpressure environment,
// reference record stream computed from the sweep rules.
module tb_sweep_acq_multi_ctrl;
    localparam int DW = 10;
    localparam int ND = 3;

    logic clk;
    logic rst_n;

    sweep_acq_multi_ctrl_if bus ();

    sweep_acq_multi_ctrl dut (
        .Clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0]      got_words[$];
    logic [ND*DW-1:0] outdac_log[$];
    int               acq_lens[$];
    int               loads, forces, acq_len;
    bit               acq_prev;

    logic [15:0] exp_words[$];
    int          exp_dac[$];
    int          exp_ch, exp_start;

    int cur_pkts;
    bit stray_en, bp_rand, bp_force;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor, sampled on the falling edge.
    initial begin
        loads = 0; forces = 0; acq_len = 0; acq_prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acq_prev = 0;
            end else begin
                if (bus.SweepACQData_en) got_words.push_back(bus.SweepACQData);
                if (bus.LoadSCParameter) loads++;
                if (bus.ForceMicrorocAcqReset) begin
                    forces++;
                    acq_lens.push_back(acq_len);
                end
                if (bus.SingleACQStart) begin
                    if (!acq_prev) begin
                        outdac_log.push_back(bus.OutDAC);
                        acq_len = 0;
                    end
                    acq_len++;
                end
                acq_prev = bus.SingleACQStart;
            end
        end
    end

    // SC configuration responder.
    initial begin
        bus.MicrorocConfigDone = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.LoadSCParameter) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 bus.MicrorocConfigDone = 1'b1;
                @(posedge clk);
                #1 bus.MicrorocConfigDone = 1'b0;
            end
        end
    end

    // Package source: cur_pkts pulses per acquisition with random gaps, stray pulses otherwise.
    initial begin
        int issued, gap;
        issued = 0; gap = 0;
        bus.ParallelData_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.SingleACQStart) begin
                if (issued < cur_pkts && gap == 0) begin
                    bus.ParallelData_en = 1'b1;
                    issued++;
                    gap = $urandom_range(0, 2);
                end else begin
                    bus.ParallelData_en = 1'b0;
                    if (gap > 0) gap--;
                end
            end else begin
                issued = 0;
                gap = 0;
                bus.ParallelData_en = stray_en && ($urandom_range(0, 7) == 0);
            end
        end
    end

    // FIFO backpressure.
    initial begin
        bus.UsbDataFifoFull = 1'b0;
        forever begin
            @(posedge clk);
            #2 bus.UsbDataFifoFull = bp_force | (bp_rand && ($urandom_range(0, 3) == 0));
        end
    end

    task automatic add_record(input int ch, input int dac, input int tflag, input int cnt);
        exp_words.push_back((16'hC0C0 & 16'hFFFC) | 16'(ch));
        exp_words.push_back(16'(tflag << 15) | 16'(dac));
        exp_words.push_back(16'(cnt));
    endtask

    task automatic build_normal(input int ch, input int s, input int e, input int step,
                                input int max, input int pkts);
        int st, v;
        st = (step == 0) ? 1 : step;
        v  = s;
        exp_words.delete();
        exp_dac.delete();
        exp_ch = ch;
        exp_start = s;
        while ((s <= e) ? (v <= e) : (v >= e)) begin
            if (v < 0 || v > 1023) break;
            exp_dac.push_back(v);
            v += (s <= e) ? st : -st;
        end
        foreach (exp_dac[i])
            add_record(ch, exp_dac[i], (pkts >= max) ? 0 : 1, (pkts >= max) ? max : pkts);
        exp_words.push_back(16'hFFFF);
    endtask

    function automatic logic [ND*DW-1:0] exp_outdac(input int dac);
        logic [ND*DW-1:0] r;
        r = '0;
        for (int c = 0; c < ND; c++)
            r[c*DW +: DW] = (c == exp_ch) ? DW'(dac) : DW'(exp_start);
        return r;
    endfunction

    task automatic start_sweep(input int ch, input int s, input int e, input int step,
                               input int max, input int pkts, input int to);
        @(posedge clk);
        #1;
        bus.DacSelect        = 2'(ch);
        bus.StartDAC         = DW'(s);
        bus.EndDAC           = DW'(e);
        bus.DacStep          = DW'(step);
        bus.MaxPackageNumber = 16'(max);
        bus.AcqTimeout       = 24'(to);
        cur_pkts = pkts;
        got_words.delete();
        outdac_log.delete();
        acq_lens.delete();
        loads = 0;
        forces = 0;
        bus.SweepStart = 1'b1;
        @(posedge clk);
        #1 bus.SweepStart = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " OutDAC"}, 64'(bus.OutDAC), 64'd0);
        chk({tag, " LoadSC"}, 64'(bus.LoadSCParameter), 64'd0);
        chk({tag, " AcqStart"}, 64'(bus.SingleACQStart), 64'd0);
        chk({tag, " ForceRst"}, 64'(bus.ForceMicrorocAcqReset), 64'd0);
        chk({tag, " Data"}, 64'(bus.SweepACQData), 64'd0);
        chk({tag, " Data_en"}, 64'(bus.SweepACQData_en), 64'd0);
        chk({tag, " ACQDone"}, 64'(bus.ACQDone), 64'd0);
        chk({tag, " Busy"}, 64'(bus.SweepBusy), 64'd0);
    endtask

    task automatic finish_sweep(input string tag);
        bit ok;
        int n;
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus.ACQDone) begin ok = 1; break; end
        end
        chk({tag, " reach ACQDone"}, 64'(ok), 64'd1);
        chk({tag, " word count"}, 64'(got_words.size()), 64'(exp_words.size()));
        n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s word%0d", tag, i), 64'(got_words[i]), 64'(exp_words[i]));
        chk({tag, " points"}, 64'(outdac_log.size()), 64'(exp_dac.size()));
        chk({tag, " load pulses"}, 64'(loads), 64'(exp_dac.size()));
        n = (outdac_log.size() < exp_dac.size()) ? outdac_log.size() : exp_dac.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s OutDAC%0d", tag, i), 64'(outdac_log[i]), 64'(exp_outdac(exp_dac[i])));
        if (ok) begin
            repeat (3) @(negedge clk);
            chk({tag, " ACQDone held"}, 64'(bus.ACQDone), 64'd1);
            chk({tag, " busy in DONE"}, 64'(bus.SweepBusy), 64'd1);
            @(posedge clk);
            #1 bus.DataTransmitDone = 1'b1;
            @(posedge clk);
            #1 bus.DataTransmitDone = 1'b0;
            @(negedge clk);
            chk({tag, " ACQDone cleared"}, 64'(bus.ACQDone), 64'd0);
            chk({tag, " idle after ack"}, 64'(bus.SweepBusy), 64'd0);
        end else begin
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int ch, s, e, step, max, pkts;
        rst_n = 1'b0;
        bus.SweepStart = 0; bus.SweepStop = 0; bus.DacSelect = 0;
        bus.StartDAC = 0; bus.EndDAC = 0; bus.DacStep = 0;
        bus.MaxPackageNumber = 0; bus.AcqTimeout = 0; bus.DataTransmitDone = 0;
        cur_pkts = 0; stray_en = 1; bp_rand = 0; bp_force = 0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Long ascending sweep under random backpressure.
        bp_rand = 1;
        start_sweep(0, 475, 525, 1, 10, 10, 0);
        build_normal(0, 475, 525, 1, 10, 10);
        finish_sweep("asc51");
        bp_rand = 0;

        // Step 5 must stop at 10; a second SweepStart while busy is ignored.
        max = $urandom_range(0, 4);
        pkts = max + $urandom_range(0, 2);
        start_sweep(2, 0, 12, 5, max, pkts, 0);
        build_normal(2, 0, 12, 5, max, pkts);
        repeat (15) @(posedge clk);
        #1 bus.SweepStart = 1'b1;
        @(posedge clk);
        #1 bus.SweepStart = 1'b0;
        finish_sweep("step5");

        max = $urandom_range(1, 5);
        start_sweep(1, 20, 10, 4, max, max, 0);
        build_normal(1, 20, 10, 4, max, max);
        finish_sweep("desc");

        // Timeout exit: each acquisition lasts exactly AcqTimeout cycles.
        s = $urandom_range(100, 900);
        start_sweep(0, s, s + 2, 1, 10, 3, 100);
        build_normal(0, s, s + 2, 1, 10, 3);
        finish_sweep("timeout");
        chk("timeout acq count", 64'(acq_lens.size()), 64'd3);
        foreach (acq_lens[i])
            chk($sformatf("timeout acq len%0d", i), 64'(acq_lens[i]), 64'd100);

        // Range edges: wrap above 1023 and below 0 must end the sweep.
        start_sweep(1, 1017, 1023, 3, 1, 1, 0);
        build_normal(1, 1017, 1023, 3, 1, 1);
        finish_sweep("top edge");
        start_sweep(2, 5, 0, 2, 1, 1, 0);
        build_normal(2, 5, 0, 2, 1, 1);
        finish_sweep("bottom edge");

        // Four-cycle stall on WR1 of the first record.
        start_sweep(1, 5, 9, 2, 2, 2, 0);
        build_normal(1, 5, 9, 2, 2, 2);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (got_words.size() == 1) begin ok = 1; break; end
        end
        chk("bp reach WR1", 64'(ok), 64'd1);
        bp_force = 1;
        repeat (4) begin
            @(negedge clk);
            chk("bp stall Data_en", 64'(bus.SweepACQData_en), 64'd0);
            chk("bp hold word", 64'(bus.SweepACQData), 64'(exp_words[1]));
        end
        @(posedge clk);
        #1 bp_force = 0;
        finish_sweep("bp");

        // Random sweeps, including step 0 treated as 1.
        for (int r = 0; r < 3; r++) begin
            ch = $urandom_range(0, 2);
            s = $urandom_range(0, 1023);
            e = s + int'($urandom_range(0, 60)) - 30;
            if (e < 0) e = 0;
            if (e > 1023) e = 1023;
            step = (r == 0) ? 0 : int'($urandom_range(1, 9));
            max = $urandom_range(1, 3);
            bp_rand = 1;
            start_sweep(ch, s, e, step, max, max, 0);
            build_normal(ch, s, e, step, max, max);
            finish_sweep($sformatf("rand%0d", r));
            bp_rand = 0;
        end

        // Abort during the 3rd acquisition.
        start_sweep(0, 50, 80, 3, 5, 0, 20);
        exp_words.delete();
        exp_dac.delete();
        exp_ch = 0;
        exp_start = 50;
        exp_dac.push_back(50); exp_dac.push_back(53); exp_dac.push_back(56);
        add_record(0, 50, 1, 0);
        add_record(0, 53, 1, 0);
        add_record(0, 56, 0, 0);
        exp_words.push_back(16'hFFFF);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (loads == 3 && bus.SingleACQStart) begin ok = 1; break; end
        end
        chk("stop reach 3rd ACQ", 64'(ok), 64'd1);
        repeat (5) @(posedge clk);
        #1 bus.SweepStop = 1'b1;
        @(posedge clk);
        #1 bus.SweepStop = 1'b0;
        finish_sweep("stop");
        chk("stop force pulses", 64'(forces), 64'd3);

        // Reset during WR0 clears everything and prevents further writes.
        start_sweep(0, 300, 310, 1, 2, 2, 0);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (bus.SweepACQData_en) begin ok = 1; break; end
        end
        chk("rst reach WR0", 64'(ok), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid-sweep reset");
        got_words.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst no writes", 64'(got_words.size()), 64'd0);
        chk("rst idle", 64'(bus.SweepBusy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
